alarm_scheduler: RTL

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_scheduler_pkg.sv | 30 +++
 rtl/alarm_slot_match.sv | 54 +++++
 rtl/alarm_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// alarm_scheduler_pkg
// Shared time-of-day constants, ring-length decoding and the scheduler FSM
// state type used by alarm_scheduler and alarm_slot_match.
// ---------------------------------------------------------------------------
package alarm_scheduler_pkg;

    localparam int SEC_PER_DAY = 86400;
    localparam int SEC_W       = 17;    // enough for 0..86399
    localparam int REMAIN_W    = 6;     // enough for the longest ring (60 s)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    // Ring length code to seconds: 0=15, 1=30, 2=45, 3=60.
    function automatic logic [REMAIN_W-1:0] len_to_sec(input logic [1:0] code);
        logic [REMAIN_W-1:0] secs;
        case (code)
            2'd0:    secs = 6'd15;
            2'd1:    secs = 6'd30;
            2'd2:    secs = 6'd45;
            default: secs = 6'd60;
        endcase
        return secs;
    endfunction

endpackage

// File: rtl/alarm_slot_match.sv
// ---------------------------------------------------------------------------
// alarm_slot_match
// One alarm slot: holds the configured target second, ring length code and
// enable, and flags a match on the sec_tick where cur_sec equals the target.
//
// Ports
//   clk, rst       clock and asynchronous active-high reset
//   wr_en_i        write strobe already qualified for this slot
//   wr_sec_i       target second to store (out-of-range values stored as-is)
//   wr_len_i       ring length code to store
//   wr_enable_i    enable to store
//   sec_tick_i     one-clk strobe per second
//   cur_sec_i      current time of day
//   match_o        slot enabled, in range and equal to cur_sec on a tick
//   len_o          stored ring length code
// ---------------------------------------------------------------------------
module alarm_slot_match
    import alarm_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [SEC_W-1:0] wr_sec_i,
    input  logic [1:0]       wr_len_i,
    input  logic             wr_enable_i,
    input  logic             sec_tick_i,
    input  logic [SEC_W-1:0] cur_sec_i,
    output logic             match_o,
    output logic [1:0]       len_o
);

    logic [SEC_W-1:0] sec_q;
    logic [1:0]       len_q;
    logic             enable_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_q    <= '0;
            len_q    <= '0;
            enable_q <= 1'b0;
        end else if (wr_en_i) begin
            sec_q    <= wr_sec_i;
            len_q    <= wr_len_i;
            enable_q <= wr_enable_i;
        end
    end

    // The range guard keeps an out-of-range target from ever firing, even if
    // cur_sec were driven with the same illegal value.
    assign match_o = sec_tick_i && enable_q && (sec_q == cur_sec_i) &&
                     (sec_q < SEC_W'(SEC_PER_DAY));
    assign len_o   = len_q;

endmodule

// File: rtl/alarm_scheduler.sv
// ---------------------------------------------------------------------------
// alarm_scheduler
// Shares one buzzer output between N_ALARM alarm slots. Matching slots are
// arbitrated lowest-index-first; losers and slots matching while another is
// being serviced wait in the pending vector. A ringing alarm can be stopped
// (off) or snoozed up to MAX_SNOOZE times for SNOOZE_SEC seconds.
//
// Ports
//   clk, rst       clock and asynchronous active-high reset
//   sec_tick       one-clk strobe per second
//   cur_sec        current time of day, 0..86399
//   wr_en          slot configuration write strobe
//   wr_idx         slot being written
//   wr_sec         target second for the slot
//   wr_len         ring length code (15/30/45/60 s)
//   wr_enable      slot enable
//   off            stop ringing (one-clk pulse)
//   snooze         snooze ringing (one-clk pulse)
//   alarming       buzzer drive (registered)
//   active_idx     slot being serviced, 0 when idle (registered)
//   snooze_cnt     snoozes used in the current event (registered)
//   pending        slots that matched and await service (registered)
// ---------------------------------------------------------------------------
module alarm_scheduler
    import alarm_scheduler_pkg::*;
#(
    parameter int N_ALARM    = 4,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sec_tick,
    input  logic [SEC_W-1:0]   cur_sec,
    input  logic               wr_en,
    input  logic [1:0]         wr_idx,
    input  logic [SEC_W-1:0]   wr_sec,
    input  logic [1:0]         wr_len,
    input  logic               wr_enable,
    input  logic               off,
    input  logic               snooze,
    output logic               alarming,
    output logic [1:0]         active_idx,
    output logic [1:0]         snooze_cnt,
    output logic [N_ALARM-1:0] pending
);

    localparam logic [1:0] MAX_SN = 2'(MAX_SNOOZE);

    state_e                state_q, state_d;
    logic [1:0]            active_q, active_d;
    logic [1:0]            snooze_cnt_q, snooze_cnt_d;
    logic [REMAIN_W-1:0]   remain_q, remain_d;
    logic [SEC_W-1:0]      target_q, target_d;
    logic [N_ALARM-1:0]    pending_q, pending_d;
    logic                  alarming_q, alarming_d;

    logic [N_ALARM-1:0]    match;
    logic [1:0]            slot_len [N_ALARM];
    logic [N_ALARM-1:0]    one_hot;
    logic [N_ALARM-1:0]    active_oh;
    logic [N_ALARM-1:0]    clr_mask;
    logic [N_ALARM-1:0]    cand;
    logic [1:0]            win_idx;
    logic                  dis_active;
    logic [SEC_W:0]        snooze_sum;
    logic [SEC_W-1:0]      snooze_target;

    for (genvar g = 0; g < N_ALARM; g++) begin : g_slot
        alarm_slot_match u_slot (
            .clk         (clk),
            .rst         (rst),
            .wr_en_i     (wr_en && (wr_idx == 2'(g))),
            .wr_sec_i    (wr_sec),
            .wr_len_i    (wr_len),
            .wr_enable_i (wr_enable),
            .sec_tick_i  (sec_tick),
            .cur_sec_i   (cur_sec),
            .match_o     (match[g]),
            .len_o       (slot_len[g])
        );
    end

    assign one_hot   = {{(N_ALARM-1){1'b0}}, 1'b1};
    assign active_oh = one_hot << active_q;
    // A write that disables a slot withdraws it from pending and arbitration.
    assign clr_mask  = (wr_en && !wr_enable) ? (one_hot << wr_idx) : '0;
    assign cand      = (match | pending_q) & ~clr_mask;
    assign dis_active = wr_en && !wr_enable && (wr_idx == active_q);

    // Snooze target wraps at midnight.
    assign snooze_sum    = {1'b0, cur_sec} + (SEC_W+1)'(SNOOZE_SEC);
    assign snooze_target = (snooze_sum >= (SEC_W+1)'(SEC_PER_DAY)) ?
                           SEC_W'(snooze_sum - (SEC_W+1)'(SEC_PER_DAY)) :
                           snooze_sum[SEC_W-1:0];

    // Lowest-index candidate wins.
    always_comb begin
        win_idx = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (cand[i]) win_idx = 2'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        snooze_cnt_d = snooze_cnt_q;
        remain_d     = remain_q;
        target_d     = target_q;
        // While servicing, new matches of other slots queue up; a re-match of
        // the serviced slot is dropped.
        pending_d    = (pending_q | (match & ~active_oh)) & ~clr_mask;

        case (state_q)
            IDLE: begin
                pending_d = cand;
                if (cand != '0) begin
                    state_d      = RING;
                    active_d     = win_idx;
                    snooze_cnt_d = '0;
                    pending_d    = cand & ~(one_hot << win_idx);
                    // A tick in the entry cycle already counts as one ring second.
                    remain_d     = len_to_sec(slot_len[win_idx]) -
                                   (sec_tick ? 6'd1 : 6'd0);
                end
            end
            RING: begin
                if (dis_active || off) begin
                    state_d  = IDLE;
                    active_d = '0;
                    remain_d = '0;
                end else if (snooze && (snooze_cnt_q < MAX_SN)) begin
                    state_d      = SNOOZE;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                    target_d     = snooze_target;
                end else if (sec_tick) begin
                    if (remain_q <= 6'd1) begin
                        state_d  = IDLE;
                        active_d = '0;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - 6'd1;
                    end
                end
            end
            SNOOZE: begin
                if (dis_active || off) begin
                    state_d  = IDLE;
                    active_d = '0;
                    remain_d = '0;
                end else if (sec_tick && (cur_sec == target_q)) begin
                    state_d  = RING;
                    remain_d = len_to_sec(slot_len[active_q]) - 6'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                active_d = '0;
            end
        endcase

        alarming_d = (state_d == RING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            active_q     <= '0;
            snooze_cnt_q <= '0;
            remain_q     <= '0;
            target_q     <= '0;
            pending_q    <= '0;
            alarming_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            snooze_cnt_q <= snooze_cnt_d;
            remain_q     <= remain_d;
            target_q     <= target_d;
            pending_q    <= pending_d;
            alarming_q   <= alarming_d;
        end
    end

    assign alarming   = alarming_q;
    assign active_idx = active_q;
    assign snooze_cnt = snooze_cnt_q;
    assign pending    = pending_q;

endmodule
